hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the five-stage mini CPU. It produces the `valid` (advance) and `flush` (bubble) strobes for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus `pc_write`. The ID/EX control register consumes `id_ex_valid` and `id_ex_flush` directly. The block resolves three hazards: data-memory wait, branch/jump redirect resolved in MEM, and load-use. It also tracks memory-wait duration for timeout detection and keeps saturating stall/flush performance counters.

## Interface
- `TIMEOUT`, default 64: consecutive memory-stall cycles that set `mem_timeout`; legal range 2..65535.
- `CNT_W`, default 32: width of the performance counters.

- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `id_rs1`, `id_rs2`  in  5 each  source register indices of the instruction in ID
- `id_rs1_used`, `id_rs2_used`  in  1 each  the ID instruction reads that source
- `ex_rd`  in  5  destination register of the instruction in EX
- `ex_mem_read`  in  1  the EX instruction is a load (`out_mem_ctrl_mem_read` of ID/EX)
- `mem_taken`  in  1  the MEM instruction redirects the PC (branch taken or jump)
- `mem_req`  in  1  the MEM instruction accesses data memory (read or write)
- `dmem_ready`  in  1  data memory completes the access this cycle
- `pc_write`  out  1  PC may update
- `if_id_valid`, `if_id_flush`  out  1 each
- `id_ex_valid`, `id_ex_flush`  out  1 each
- `ex_mem_valid`, `ex_mem_flush`  out  1 each
- `mem_wb_valid`, `mem_wb_flush`  out  1 each
- `mem_timeout`  out  1  sticky: a memory stall reached `TIMEOUT` cycles
- `stall_cycles`  out  `CNT_W`  count of cycles with `mem_stall` or `load_use`
- `flush_events`  out  `CNT_W`  count of cycles with `redirect`

## Operation
Combinational terms, evaluated in priority order:
- `mem_stall = mem_req & ~dmem_ready`
- `redirect = mem_taken & ~mem_stall`
- `load_use = ex_mem_read & (ex_rd != 0) & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd)) & ~mem_stall & ~redirect`

Strobe outputs:
- `pc_write = ~mem_stall & ~load_use`. On a redirect, `pc_write` is 1 so the PC loads the target.
- `if_id_valid = ~mem_stall & ~load_use`; `if_id_flush = redirect`.
- `id_ex_valid = ~mem_stall`; `id_ex_flush = redirect | load_use`.
- `ex_mem_valid = ~mem_stall`; `ex_mem_flush = redirect`.
- `mem_wb_valid = 1`; `mem_wb_flush = mem_stall`. WB drains while MEM waits.

Hazard interactions:
- A redirect raised during a memory stall is deferred, not lost. The MEM register holds, so `mem_taken` persists and takes effect in the cycle `dmem_ready` rises.

Wait FSM (states RUN and MWAIT, with a 16-bit `wait_cnt`):
- RUN: if `mem_stall`, go to MWAIT with `wait_cnt <= 1`; otherwise stay.
- MWAIT: if `~mem_stall`, go to RUN with `wait_cnt <= 0`. Otherwise `wait_cnt <= wait_cnt + 1`, saturating at `TIMEOUT`.
- On any edge where `mem_stall & (wait_cnt == TIMEOUT-1)`, set `mem_timeout <= 1`. The flag clears only on reset.

Counters:
- `stall_cycles` increments on each edge where `mem_stall | load_use`.
- `flush_events` increments on each edge where `redirect`.
- Both saturate at all-ones and never wrap.

## Timing
- The strobes are purely combinational from the current inputs. Zero latency: they act on the same clock edge as the hazard.
- While `reset` is high, all strobes are forced to 0 (`pc_write`, every `*_valid` and every `*_flush`).
- Reset values: state RUN, `wait_cnt` 0, `mem_timeout` 0, `stall_cycles` 0, `flush_events` 0.
- Load-use inserts exactly one bubble. On the next cycle the load has moved to MEM, so `load_use` drops.
- Memory stall of N cycles: all `*_valid` except `mem_wb_valid` are low for N cycles, and N bubbles enter MEM/WB.
- Reset asserted mid-MWAIT returns to RUN at once and clears `wait_cnt` and `mem_timeout`.

## Test plan
- Load-use: `ex_mem_read=1`, `ex_rd=5`, `id_rs2=5`, `id_rs2_used=1` for one cycle -> `pc_write=0`, `if_id_valid=0`, `id_ex_flush=1`; `stall_cycles` goes 0→1. Repeat with `ex_rd=0` -> no stall.
- Redirect: `mem_taken=1`, `mem_req=0` -> `if_id_flush`, `id_ex_flush` and `ex_mem_flush` all 1, `pc_write=1`; `flush_events=1`.
- Memory wait: `mem_req=1`, `dmem_ready=0` for 3 cycles, then `dmem_ready=1` -> `id_ex_valid=0` and `mem_wb_flush=1` for 3 cycles; `stall_cycles=3`; FSM returns to RUN.
- Deferred redirect: `mem_taken=1` with a 2-cycle memory wait -> no flushes during the wait; flushes fire in the cycle `dmem_ready=1`; `flush_events=1`.
- Timeout: `TIMEOUT=4`, `mem_req=1`, `dmem_ready=0` held -> `mem_timeout` rises after the 4th stall edge and stays high after `dmem_ready=1`; `reset` pulse clears it.
- Simultaneous load-use and redirect -> redirect wins: `id_ex_flush=1`, `if_id_flush=1`, `pc_write=1`, `stall_cycles` unchanged.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: hazard inputs from the pipeline, stage strobes and
// performance/timeout status back out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             mem_taken;
  logic             mem_req;
  logic             dmem_ready;
  logic             pc_write;
  logic             if_id_valid;
  logic             if_id_flush;
  logic             id_ex_valid;
  logic             id_ex_flush;
  logic             ex_mem_valid;
  logic             ex_mem_flush;
  logic             mem_wb_valid;
  logic             mem_wb_flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
           mem_taken, mem_req, dmem_ready,
    input  pc_write, if_id_valid, if_id_flush, id_ex_valid, id_ex_flush,
           ex_mem_valid, ex_mem_flush, mem_wb_valid, mem_wb_flush,
           mem_timeout, stall_cycles, flush_events
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
           mem_taken, mem_req, dmem_ready,
    output pc_write, if_id_valid, if_id_flush, id_ex_valid, id_ex_flush,
           ex_mem_valid, ex_mem_flush, mem_wb_valid, mem_wb_flush,
           mem_timeout, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard/stall controller: memory wait, MEM-resolved
// redirect and load-use, plus memory-wait timeout and saturating perf counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  typedef enum logic {RUN, MWAIT} state_t;

  localparam logic [15:0] TIMEOUT_C  = 16'(TIMEOUT);
  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  logic [15:0]      r_wait_cnt;
  logic             r_mem_timeout;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_events;

  logic w_mem_stall;
  logic w_redirect;
  logic w_src_match;
  logic w_load_use;
  logic w_run;

  // A memory stall masks everything below it; a redirect held by the stall
  // stays in MEM and fires on the cycle the access completes.
  assign w_mem_stall = bus.mem_req & ~bus.dmem_ready;
  assign w_redirect  = bus.mem_taken & ~w_mem_stall;
  assign w_src_match = (bus.id_rs1_used & (bus.id_rs1 == bus.ex_rd)) |
                       (bus.id_rs2_used & (bus.id_rs2 == bus.ex_rd));
  assign w_load_use  = bus.ex_mem_read & (bus.ex_rd != 5'd0) & w_src_match &
                       ~w_mem_stall & ~w_redirect;
  assign w_run       = ~reset;

  assign bus.pc_write     = w_run & ~w_mem_stall & ~w_load_use;
  assign bus.if_id_valid  = w_run & ~w_mem_stall & ~w_load_use;
  assign bus.if_id_flush  = w_run & w_redirect;
  assign bus.id_ex_valid  = w_run & ~w_mem_stall;
  assign bus.id_ex_flush  = w_run & (w_redirect | w_load_use);
  assign bus.ex_mem_valid = w_run & ~w_mem_stall;
  assign bus.ex_mem_flush = w_run & w_redirect;
  assign bus.mem_wb_valid = w_run;
  assign bus.mem_wb_flush = w_run & w_mem_stall;

  assign bus.mem_timeout  = r_mem_timeout;
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_events = r_flush_events;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= RUN;
      r_wait_cnt    <= 16'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mem_stall) begin
            r_state    <= MWAIT;
            r_wait_cnt <= 16'd1;
          end
        end
        MWAIT: begin
          if (!w_mem_stall) begin
            r_state    <= RUN;
            r_wait_cnt <= 16'd0;
          end else if (r_wait_cnt < TIMEOUT_C) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        default: begin
          r_state    <= RUN;
          r_wait_cnt <= 16'd0;
        end
      endcase
      if (w_mem_stall && (r_wait_cnt == TIMEOUT_M1))
        r_mem_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if ((w_mem_stall || w_load_use) && (r_stall_cycles != CNT_MAX))
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_redirect && (r_flush_events != CNT_MAX))
        r_flush_events <= r_flush_events + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with TIMEOUT=4 and 4-bit counters so the
// timeout and counter saturation are reachable in a few cycles.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  // Packed strobe order: pc, if_v, if_f, idex_v, idex_f, exmem_v, exmem_f, memwb_v, memwb_f
  localparam logic [8:0] S_RESET  = 9'b0_00_00_00_00;
  localparam logic [8:0] S_NORMAL = 9'b1_10_10_10_10;
  localparam logic [8:0] S_LDUSE  = 9'b0_00_11_10_10;
  localparam logic [8:0] S_REDIR  = 9'b1_11_11_11_10;
  localparam logic [8:0] S_MSTALL = 9'b0_00_00_00_11;

  logic clk;
  logic reset;
  int   vectors;
  int   errors;

  hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] strobes();
    return {bus.pc_write, bus.if_id_valid, bus.if_id_flush, bus.id_ex_valid,
            bus.id_ex_flush, bus.ex_mem_valid, bus.ex_mem_flush,
            bus.mem_wb_valid, bus.mem_wb_flush};
  endfunction

  task automatic applyStimulus(input logic [4:0] rs1, input logic rs1u,
                               input logic [4:0] rs2, input logic rs2u,
                               input logic [4:0] exrd, input logic exmr,
                               input logic taken, input logic req,
                               input logic ready);
    bus.id_rs1      = rs1;
    bus.id_rs1_used = rs1u;
    bus.id_rs2      = rs2;
    bus.id_rs2_used = rs2u;
    bus.ex_rd       = exrd;
    bus.ex_mem_read = exmr;
    bus.mem_taken   = taken;
    bus.mem_req     = req;
    bus.dmem_ready  = ready;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkRegs(input string tag, input logic [31:0] stall,
                           input logic [31:0] flush, input logic tmo);
    checkOutput({tag, "_stall"}, 32'(bus.stall_cycles), stall);
    checkOutput({tag, "_flush"}, 32'(bus.flush_events), flush);
    checkOutput({tag, "_tmo"}, 32'(bus.mem_timeout), 32'(tmo));
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    reset   = 1'b1;
    // Hazards present during reset must not leak onto the strobes
    applyStimulus(5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    checkOutput("reset_strobes", 32'(strobes()), 32'(S_RESET));
    checkRegs("reset", 0, 0, 1'b0);
    reset = 1'b0;

    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle", 32'(strobes()), 32'(S_NORMAL));
    step();
    checkRegs("idle", 0, 0, 1'b0);

    applyStimulus(5'd1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lduse_rs2", 32'(strobes()), 32'(S_LDUSE));
    step();
    checkRegs("lduse_rs2", 1, 0, 1'b0);

    applyStimulus(5'd7, 1'b1, 5'd2, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lduse_rs1", 32'(strobes()), 32'(S_LDUSE));
    step();
    checkRegs("lduse_rs1", 2, 0, 1'b0);

    applyStimulus(5'd7, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lduse_unused", 32'(strobes()), 32'(S_NORMAL));
    step();

    applyStimulus(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lduse_x0", 32'(strobes()), 32'(S_NORMAL));
    step();

    applyStimulus(5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("no_load", 32'(strobes()), 32'(S_NORMAL));
    step();
    checkRegs("no_stall", 2, 0, 1'b0);

    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("redirect", 32'(strobes()), 32'(S_REDIR));
    step();
    checkRegs("redirect", 2, 1, 1'b0);

    applyStimulus(5'd1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("redir_over_lduse", 32'(strobes()), 32'(S_REDIR));
    step();
    checkRegs("redir_over_lduse", 2, 2, 1'b0);

    // Three-cycle memory wait; a load-use pattern in the middle is masked
    for (int i = 0; i < 3; i++) begin
      if (i == 1)
        applyStimulus(5'd1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
      else
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("mwait_%0d", i), 32'(strobes()), 32'(S_MSTALL));
      step();
    end
    checkRegs("mwait", 5, 2, 1'b0);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("mwait_done", 32'(strobes()), 32'(S_NORMAL));
    step();
    checkRegs("mwait_done", 5, 2, 1'b0);

    for (int i = 0; i < 2; i++) begin
      applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput($sformatf("defer_wait_%0d", i), 32'(strobes()), 32'(S_MSTALL));
      step();
    end
    checkRegs("defer_wait", 7, 2, 1'b0);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("defer_fire", 32'(strobes()), 32'(S_REDIR));
    step();
    checkRegs("defer_fire", 7, 3, 1'b0);

    // Timeout sets on the fourth consecutive stall edge; counter then saturates
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) step();
    checkRegs("tmo_edge3", 10, 3, 1'b0);
    step();
    checkRegs("tmo_edge4", 11, 3, 1'b1);
    for (int i = 0; i < 6; i++) step();
    checkRegs("stall_sat", 15, 3, 1'b1);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    checkRegs("tmo_sticky", 15, 3, 1'b1);

    // Asynchronous reset in the middle of a wait, away from a clock edge
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midwait_reset_strobes", 32'(strobes()), 32'(S_RESET));
    checkRegs("midwait_reset", 0, 0, 1'b0);
    step();
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) step();
    checkRegs("post_reset_edge3", 3, 0, 1'b0);
    step();
    checkRegs("post_reset_edge4", 4, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
